// File: rtl/ascon_pkg.sv
// Shared definitions for the ASCON register-file bus master: register map,
// FSM states, CTRL field layout and the registered bus-beat payload.
package ascon_pkg;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_KEY0     = 8'h08;
    localparam logic [7:0] REG_NONCE0   = 8'h20;
    localparam logic [7:0] REG_BDI      = 8'h30;
    localparam logic [7:0] REG_BDI_TYPE = 8'h34;
    localparam logic [7:0] REG_BDO      = 8'h38;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_MODE_LSB  = 1;
    localparam int unsigned CTRL_MODE_W    = 4;

    typedef enum logic [3:0] {
        IDLE, KEY, NONCE, CTRL, TYPE, DATA, POLL, WAIT_ST, RD_BDO, WAIT_BDO, CLR, RESP
    } state_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } bus_beat_t;

    function automatic bus_beat_t wr_beat(input logic [7:0] addr, input logic [31:0] data);
        return '{req: 1'b1, we: 1'b1, addr: addr, wdata: data};
    endfunction

    function automatic bus_beat_t rd_beat(input logic [7:0] addr);
        return '{req: 1'b1, we: 1'b0, addr: addr, wdata: 32'h0};
    endfunction

    function automatic logic [31:0] ctrl_word(input logic [CTRL_MODE_W-1:0] mode);
        logic [31:0] w;
        w = '0;
        w[CTRL_START_BIT] = 1'b1;
        w[CTRL_MODE_LSB +: CTRL_MODE_W] = mode;
        return w;
    endfunction

endpackage

// File: rtl/ascon_bus_master.sv
// Bus initiator: programs key/nonce/control of the ASCON register block,
// streams BDI words, polls STATUS, reads BDO and returns one result per job.
module ascon_bus_master
    import ascon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned POLL_MAX   = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [3:0]            cmd_mode_i,
    input  logic [127:0]          cmd_key_i,
    input  logic [95:0]           cmd_nonce_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [3:0]            in_type_i,
    input  logic                  in_last_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] res_bdo_o,
    output logic                  res_auth_o,
    output logic                  res_timeout_o,
    output logic                  busy_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rvalid_i
);

    localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d, idx_n;
    logic [POLL_W-1:0]       poll_q, poll_d;
    logic                    type_known_q, type_known_d;
    logic [3:0]              last_type_q, last_type_d;
    logic [3:0]              mode_q, mode_d;
    logic [127:0]            key_q, key_d;
    logic [95:0]             nonce_q, nonce_d;
    bus_beat_t               beat_q, beat_d;
    logic                    res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0]   res_bdo_q, res_bdo_d;
    logic                    res_auth_q, res_auth_d;
    logic                    res_timeout_q, res_timeout_d;

    assign idx_n = idx_q + 3'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            poll_q        <= '0;
            type_known_q  <= 1'b0;
            last_type_q   <= '0;
            mode_q        <= '0;
            key_q         <= '0;
            nonce_q       <= '0;
            beat_q        <= '0;
            res_valid_q   <= 1'b0;
            res_bdo_q     <= '0;
            res_auth_q    <= 1'b0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            poll_q        <= poll_d;
            type_known_q  <= type_known_d;
            last_type_q   <= last_type_d;
            mode_q        <= mode_d;
            key_q         <= key_d;
            nonce_q       <= nonce_d;
            beat_q        <= beat_d;
            res_valid_q   <= res_valid_d;
            res_bdo_q     <= res_bdo_d;
            res_auth_q    <= res_auth_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    // beat_d is the bus beat that will be on the wires during the next cycle
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        poll_d        = poll_q;
        type_known_d  = type_known_q;
        last_type_d   = last_type_q;
        mode_d        = mode_q;
        key_d         = key_q;
        nonce_d       = nonce_q;
        beat_d        = '0;
        res_valid_d   = res_valid_q;
        res_bdo_d     = res_bdo_q;
        res_auth_d    = res_auth_q;
        res_timeout_d = res_timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    mode_d        = cmd_mode_i;
                    key_d         = cmd_key_i;
                    nonce_d       = cmd_nonce_i;
                    type_known_d  = 1'b0;
                    idx_d         = '0;
                    res_bdo_d     = '0;
                    res_auth_d    = 1'b0;
                    res_timeout_d = 1'b0;
                    beat_d        = wr_beat(REG_KEY0, cmd_key_i[31:0]);
                    state_d       = KEY;
                end
            end
            KEY: begin
                if (idx_q == 3'd3) begin
                    beat_d  = wr_beat(REG_NONCE0, nonce_q[31:0]);
                    idx_d   = '0;
                    state_d = NONCE;
                end else begin
                    beat_d = wr_beat(REG_KEY0 + 8'({idx_n, 2'b00}),
                                     key_q[{idx_n[1:0], 5'd0} +: 32]);
                    idx_d  = idx_n;
                end
            end
            NONCE: begin
                if (idx_q == 3'd2) begin
                    beat_d  = wr_beat(REG_CTRL, ctrl_word(mode_q));
                    state_d = CTRL;
                end else begin
                    beat_d = wr_beat(REG_NONCE0 + 8'({idx_n, 2'b00}),
                                     nonce_q[{idx_n[1:0], 5'd0} +: 32]);
                    idx_d  = idx_n;
                end
            end
            CTRL: state_d = TYPE;
            TYPE: begin
                // BDI_TYPE is only rewritten when the word type changes
                if (in_valid_i) begin
                    if (!type_known_q || (in_type_i != last_type_q)) begin
                        beat_d       = wr_beat(REG_BDI_TYPE, 32'(in_type_i));
                        last_type_d  = in_type_i;
                        type_known_d = 1'b1;
                    end
                    state_d = DATA;
                end
            end
            DATA: begin
                if (in_valid_i) begin
                    beat_d = wr_beat(REG_BDI, 32'(in_data_i));
                    if (in_last_i) begin
                        poll_d  = '0;
                        state_d = POLL;
                    end else begin
                        state_d = TYPE;
                    end
                end
            end
            POLL: begin
                beat_d = rd_beat(REG_STATUS);
                if (poll_q != POLL_W'(POLL_MAX)) poll_d = poll_q + POLL_W'(1);
                state_d = WAIT_ST;
            end
            WAIT_ST: begin
                if (rvalid_i) begin
                    if (rdata_i[0]) begin
                        res_auth_d = rdata_i[1];
                        state_d    = RD_BDO;
                    end else if (poll_q == POLL_W'(POLL_MAX)) begin
                        res_timeout_d = 1'b1;
                        state_d       = CLR;
                    end else begin
                        state_d = POLL;
                    end
                end
            end
            RD_BDO: begin
                beat_d  = rd_beat(REG_BDO);
                state_d = WAIT_BDO;
            end
            WAIT_BDO: begin
                if (rvalid_i) begin
                    res_bdo_d = rdata_i;
                    state_d   = CLR;
                end
            end
            CLR: begin
                // START is level-sensitive, so the job ends by clearing CTRL
                beat_d      = wr_beat(REG_CTRL, 32'h0);
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_o   = (state_q == IDLE) && !rst_i;
    assign in_ready_o    = (state_q == DATA) && in_valid_i;
    assign busy_o        = (state_q != IDLE);
    assign req_o         = beat_q.req;
    assign we_o          = beat_q.we;
    assign addr_o        = ADDR_WIDTH'(beat_q.addr);
    assign wdata_o       = DATA_WIDTH'(beat_q.wdata);
    assign res_valid_o   = res_valid_q;
    assign res_bdo_o     = res_bdo_q;
    assign res_auth_o    = res_auth_q;
    assign res_timeout_o = res_timeout_q;

endmodule

// File: tb/tb_ascon_bus_master.sv
// Directed bench for ascon_bus_master: a small register-slave model answers
// reads, a monitor logs every bus beat, and logs are compared to hand-built lists.
module tb_ascon_bus_master;

    localparam int unsigned POLL_MAX = 4;
    localparam logic [127:0] KEY1   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [95:0]  NONCE1 = 96'hAAAAAAAA_55555555_00000001;
    localparam logic [95:0]  NONCE2 = 96'h01234567_89ABCDEF_DEADBEEF;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i, cmd_ready_o;
    logic [3:0]    cmd_mode_i;
    logic [127:0]  cmd_key_i;
    logic [95:0]   cmd_nonce_i;
    logic          in_valid_i, in_ready_o, in_last_i;
    logic [31:0]   in_data_i;
    logic [3:0]    in_type_i;
    logic          res_valid_o, res_ready_i, res_auth_o, res_timeout_o;
    logic [31:0]   res_bdo_o;
    logic          busy_o, req_o, we_o, rvalid_i;
    logic [7:0]    addr_o;
    logic [31:0]   wdata_o, rdata_i;

    ascon_bus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .POLL_MAX(POLL_MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_mode_i(cmd_mode_i),
        .cmd_key_i(cmd_key_i), .cmd_nonce_i(cmd_nonce_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_type_i(in_type_i), .in_last_i(in_last_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_bdo_o(res_bdo_o),
        .res_auth_o(res_auth_o), .res_timeout_o(res_timeout_o), .busy_o(busy_o),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .rdata_i(rdata_i), .rvalid_i(rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bus beat log: {we, addr, wdata}; reads log wdata as 0
    logic [40:0] got_q[$];
    int          got_cyc[$];
    logic [40:0] exp_q[$];
    int          hs_cnt = 0;
    int          cyc    = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            if (req_o === 1'b1) begin
                got_q.push_back({we_o, addr_o, we_o ? wdata_o : 32'h0});
                got_cyc.push_back(cyc);
            end
            if (in_valid_i && in_ready_o) hs_cnt++;
        end
    end

    // register-slave model: read data returned one cycle after the read beat
    logic [31:0] stat_vals [4];
    int          stat_len  = 0;
    int          stat_base = 0;
    int          rd_cnt    = 0;
    logic [31:0] bdo_val   = 32'h0;
    logic        stray     = 1'b0;
    logic        pend      = 1'b0;
    logic [7:0]  pend_addr = 8'h0;

    initial begin
        rvalid_i = 1'b0;
        rdata_i  = 32'h0;
        forever begin
            @(negedge clk_i);
            rvalid_i = 1'b0;
            if (pend) begin
                rvalid_i = 1'b1;
                if (pend_addr == 8'h04) begin
                    rdata_i = (rd_cnt - stat_base < stat_len) ? stat_vals[rd_cnt - stat_base] : 32'h0;
                    rd_cnt++;
                end else begin
                    rdata_i = bdo_val;
                end
            end
            pend      = req_o && !we_o;
            pend_addr = addr_o;
            if (stray) begin
                rvalid_i = 1'b1;
                rdata_i  = 32'h3;
            end
        end
    end

    function automatic logic [40:0] wr(input logic [7:0] a, input logic [31:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [40:0] rd(input logic [7:0] a);
        return {1'b0, a, 32'h0};
    endfunction

    task automatic push_setup(input logic [3:0] mode, input logic [127:0] key, input logic [95:0] nonce);
        for (int i = 0; i < 4; i++) exp_q.push_back(wr(8'h08 + 8'(4 * i), key[32 * i +: 32]));
        for (int i = 0; i < 3; i++) exp_q.push_back(wr(8'h20 + 8'(4 * i), nonce[32 * i +: 32]));
        exp_q.push_back(wr(8'h00, {27'b0, mode, 1'b1}));
    endtask

    task automatic start_job(input logic [3:0] mode, input logic [127:0] key, input logic [95:0] nonce);
        int base;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready_o) begin ok = 1'b1; break; end
            @(posedge clk_i); #1;
        end
        check("cmd_ready_wait", 64'(ok), 64'd1);
        base        = got_q.size();
        cmd_valid_i = 1'b1;
        cmd_mode_i  = mode;
        cmd_key_i   = key;
        cmd_nonce_i = nonce;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        check("first_write_req", 64'(req_o), 64'd1);
        check("busy_after_accept", 64'(busy_o), 64'd1);
        repeat (8) @(posedge clk_i);
        #1;
        if (got_q.size() >= base + 8) check("setup_consecutive", 64'(got_cyc[base + 7] - got_cyc[base]), 64'd7);
        else check("setup_beats", 64'(got_q.size() - base), 64'd8);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] t, input logic last, input int stall);
        bit seen;
        seen       = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_type_i  = t;
        in_last_i  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            seen = in_ready_o;
            @(posedge clk_i); #1;
            if (seen) break;
        end
        if (!seen) check("bdi_handshake_wait", 64'd0, 64'd1);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_i);
            if (i > 0) check("stall_req_low", 64'(req_o), 64'd0);
            @(posedge clk_i); #1;
        end
    endtask

    task automatic finish_job(input logic [31:0] bdo, input logic auth, input logic tmo, input int hold);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (res_valid_o) begin seen = 1'b1; break; end
        end
        check("res_valid_wait", 64'(seen), 64'd1);
        for (int i = 0; i < hold; i++) begin
            check("res_valid_hold", 64'(res_valid_o), 64'd1);
            check("res_bdo", 64'(res_bdo_o), 64'(bdo));
            check("res_auth", 64'(res_auth_o), 64'(auth));
            check("res_timeout", 64'(res_timeout_o), 64'(tmo));
            check("cmd_ready_in_resp", 64'(cmd_ready_o), 64'd0);
            @(negedge clk_i);
        end
        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        res_ready_i = 1'b0;
        check("res_valid_dropped", 64'(res_valid_o), 64'd0);
        check("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
    endtask

    task automatic compare_log(input string tag, input int base);
        check({tag, "_beat_count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < got_q.size())
                check($sformatf("%s_beat%0d", tag, i), 64'(got_q[base + i]), 64'(exp_q[i]));
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int base;
        int hs_base;
        int rd_base;
        bit seen;

        rst_i = 1'b1;
        cmd_valid_i = 1'b0; cmd_mode_i = '0; cmd_key_i = '0; cmd_nonce_i = '0;
        in_valid_i = 1'b0; in_data_i = '0; in_type_i = '0; in_last_i = 1'b0;
        res_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_req", 64'(req_o), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_res_valid", 64'(res_valid_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("post_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);

        // job 1: type change, stall, two busy polls then done with auth
        stat_vals[0] = 32'h0; stat_vals[1] = 32'h0; stat_vals[2] = 32'h3;
        stat_len = 3; stat_base = rd_cnt; bdo_val = 32'hCAFE_F00D;
        base = got_q.size(); hs_base = hs_cnt;
        push_setup(4'h2, KEY1, NONCE1);
        exp_q.push_back(wr(8'h34, 32'h1));
        exp_q.push_back(wr(8'h30, 32'h1111_1111));
        exp_q.push_back(wr(8'h30, 32'h2222_2222));
        exp_q.push_back(wr(8'h34, 32'h2));
        exp_q.push_back(wr(8'h30, 32'h3333_3333));
        repeat (3) exp_q.push_back(rd(8'h04));
        exp_q.push_back(rd(8'h38));
        exp_q.push_back(wr(8'h00, 32'h0));
        start_job(4'h2, KEY1, NONCE1);
        send_word(32'h1111_1111, 4'h1, 1'b0, 0);
        send_word(32'h2222_2222, 4'h1, 1'b0, 5);
        send_word(32'h3333_3333, 4'h2, 1'b1, 0);
        finish_job(32'hCAFE_F00D, 1'b1, 1'b0, 4);
        check("job1_in_ready_pulses", 64'(hs_cnt - hs_base), 64'd3);
        compare_log("job1", base);

        // job 2: STATUS never done -> timeout after POLL_MAX reads
        stat_len = 0; stat_base = rd_cnt; rd_base = rd_cnt; bdo_val = 32'hBAD0_BAD0;
        base = got_q.size();
        push_setup(4'hA, KEY1, NONCE2);
        exp_q.push_back(wr(8'h34, 32'h3));
        exp_q.push_back(wr(8'h30, 32'h4444_4444));
        repeat (4) exp_q.push_back(rd(8'h04));
        exp_q.push_back(wr(8'h00, 32'h0));
        start_job(4'hA, KEY1, NONCE2);
        send_word(32'h4444_4444, 4'h3, 1'b1, 0);
        finish_job(32'h0, 1'b0, 1'b1, 2);
        check("job2_status_reads", 64'(rd_cnt - rd_base), 64'd4);
        compare_log("job2", base);

        // job 3: reset while waiting on a STATUS read
        stat_len = 0; stat_base = rd_cnt;
        start_job(4'h1, KEY1, NONCE1);
        send_word(32'h5555_5555, 4'h7, 1'b1, 0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (req_o && !we_o) begin seen = 1'b1; break; end
        end
        check("job3_read_seen", 64'(seen), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_req", 64'(req_o), 64'd0);
        check("async_rst_we", 64'(we_o), 64'd0);
        check("async_rst_addr", 64'(addr_o), 64'd0);
        check("async_rst_wdata", 64'(wdata_o), 64'd0);
        check("async_rst_busy", 64'(busy_o), 64'd0);
        check("async_rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        check("async_rst_res_valid", 64'(res_valid_o), 64'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        stray = 1'b1;
        @(posedge clk_i); #1;
        stray = 1'b0;
        base = got_q.size();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("post_rst_idle_busy", 64'(busy_o), 64'd0);
            check("post_rst_idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
        end
        check("stray_rvalid_no_beats", 64'(got_q.size() - base), 64'd0);
        @(posedge clk_i); #1;

        // job 4: clean job after reset, done without auth
        stat_vals[0] = 32'h1; stat_len = 1; stat_base = rd_cnt; bdo_val = 32'h1234_5678;
        base = got_q.size();
        push_setup(4'h3, KEY1, NONCE2);
        exp_q.push_back(wr(8'h34, 32'h5));
        exp_q.push_back(wr(8'h30, 32'h6666_6666));
        exp_q.push_back(rd(8'h04));
        exp_q.push_back(rd(8'h38));
        exp_q.push_back(wr(8'h00, 32'h0));
        start_job(4'h3, KEY1, NONCE2);
        send_word(32'h6666_6666, 4'h5, 1'b1, 0);
        finish_job(32'h1234_5678, 1'b0, 1'b0, 1);
        compare_log("job4", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
